// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions for the transmit controller and the CRC block.
// The same CRC constants serve the future receiver.
package hdlc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPEN  = 3'd1,
    ST_DATA  = 3'd2,
    ST_FCS   = 3'd3,
    ST_CLOSE = 3'd4,
    ST_ABORT = 3'd5
  } hdlc_state_e;

  localparam logic [7:0]  HDLC_FLAG     = 8'h7E;
  localparam logic [15:0] CRC_POLY_REFL = 16'h8408;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_GOOD      = 16'hF0B8;

  // One serial step of the reflected CRC-16-CCITT.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    return (crc >> 1) ^ ((crc[0] ^ din) ? CRC_POLY_REFL : 16'h0000);
  endfunction

endpackage

// File: rtl/hdlc_crc16.sv
// Bit-serial reflected CRC-16-CCITT (poly 0x8408, preset 0xFFFF).
// init presets the register; ce folds din in. init wins over ce.
module hdlc_crc16
  import hdlc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init,
  input  logic        ce,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Next CRC value: preset, one serial step, or hold.
  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (ce) begin
      crc_d = crc16_step(crc_q, din);
    end
  end

  // CRC register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/hdlc_tx_ctrl.sv
// HDLC transmit controller: opening flags, zero-stuffed data, optional FCS,
// closing flag, and an abort sequence on buffer underrun.
// Optional feature: define HDLC_TX_FCS_EN to append a CRC-16-CCITT FCS.
//
// Byte handshake: a byte moves from the buffer when tx_valid and tx_ready are
// both high in the same clk_i cycle. tx_ready is only ever high together with
// bit_ce, and tx_valid low at that moment means the buffer ran dry (abort).
module hdlc_tx_ctrl
  import hdlc_pkg::*;
#(
  parameter int OPEN_FLAGS = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        txen,
  input  logic        bit_ce,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic        tx,
  output logic        txdone,
  output logic        underrun,
  output logic        busy,
  output hdlc_state_e state_dbg
);

  localparam logic [3:0] LAST_FLAG = 4'(OPEN_FLAGS - 1);
`ifdef HDLC_TX_FCS_EN
  localparam hdlc_state_e AFTER_DATA = ST_FCS;
`else
  localparam hdlc_state_e AFTER_DATA = ST_CLOSE;
`endif

  hdlc_state_e state_q, state_d;
  logic        tx_q, tx_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;   // bit index in flag/byte/FCS; 8 = tail period
  logic [3:0]  flag_cnt_q, flag_cnt_d;
  logic [7:0]  sreg_q, sreg_d;
  logic        last_q, last_d;
  logic [2:0]  ones_q, ones_d;         // run of consecutive 1s on the line
  logic        fin_q, fin_d;           // field done, one stuffed 0 still owed
  logic        txdone_q, txdone_d;
  logic        underrun_q, underrun_d;
  logic        tx_ready_c;
  logic [2:0]  ones_nx;
  logic        data_bit;

`ifdef HDLC_TX_FCS_EN
  logic        crc_init, crc_ce, crc_din;
  logic [15:0] crc;
  logic        fcs_bit;

  hdlc_crc16 u_crc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .init  (crc_init),
    .ce    (crc_ce),
    .din   (crc_din),
    .crc   (crc)
  );
`endif

  // Next-state and bit selection; everything holds unless bit_ce is high.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    bit_cnt_d  = bit_cnt_q;
    flag_cnt_d = flag_cnt_q;
    sreg_d     = sreg_q;
    last_d     = last_q;
    ones_d     = ones_q;
    fin_d      = fin_q;
    txdone_d   = 1'b0;
    underrun_d = 1'b0;
    tx_ready_c = 1'b0;
    ones_nx    = 3'd0;
    data_bit   = sreg_q[bit_cnt_q[2:0]];
`ifdef HDLC_TX_FCS_EN
    crc_init   = 1'b0;
    crc_ce     = 1'b0;
    crc_din    = data_bit;
    fcs_bit    = ~crc[bit_cnt_q];
`endif
    if (bit_ce) begin
      case (state_q)
        ST_IDLE: begin
          tx_d = 1'b1;
          if (txen && tx_valid) begin
            state_d    = ST_OPEN;
            tx_d       = HDLC_FLAG[0];
            bit_cnt_d  = 4'd1;
            flag_cnt_d = 4'd0;
`ifdef HDLC_TX_FCS_EN
            crc_init   = 1'b1;
`endif
          end
        end
        ST_OPEN: begin
          tx_d = HDLC_FLAG[bit_cnt_q[2:0]];
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            if (flag_cnt_q == LAST_FLAG) begin
              tx_ready_c = 1'b1;
              ones_d     = 3'd0;
              fin_d      = 1'b0;
              if (tx_valid) begin
                sreg_d  = tx_data;
                last_d  = tx_last;
                state_d = ST_DATA;
              end else begin
                state_d    = ST_ABORT;
                underrun_d = 1'b1;
              end
            end else begin
              flag_cnt_d = flag_cnt_q + 4'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_DATA: begin
          if (ones_q == 3'd5) begin
            tx_d   = 1'b0;
            ones_d = 3'd0;
            if (fin_q) begin
              fin_d   = 1'b0;
              state_d = AFTER_DATA;
            end
          end else begin
            tx_d    = data_bit;
            ones_nx = data_bit ? ones_q + 3'd1 : 3'd0;
            ones_d  = ones_nx;
`ifdef HDLC_TX_FCS_EN
            crc_ce  = 1'b1;
`endif
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (last_q) begin
                if (ones_nx == 3'd5) fin_d = 1'b1;
                else                 state_d = AFTER_DATA;
              end else begin
                tx_ready_c = 1'b1;
                if (tx_valid) begin
                  sreg_d = tx_data;
                  last_d = tx_last;
                end else begin
                  state_d    = ST_ABORT;
                  underrun_d = 1'b1;
                end
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
`ifdef HDLC_TX_FCS_EN
        ST_FCS: begin
          if (ones_q == 3'd5) begin
            tx_d   = 1'b0;
            ones_d = 3'd0;
            if (fin_q) begin
              fin_d   = 1'b0;
              state_d = ST_CLOSE;
            end
          end else begin
            tx_d    = fcs_bit;
            ones_nx = fcs_bit ? ones_q + 3'd1 : 3'd0;
            ones_d  = ones_nx;
            if (bit_cnt_q == 4'd15) begin
              bit_cnt_d = 4'd0;
              if (ones_nx == 3'd5) fin_d = 1'b1;
              else                 state_d = ST_CLOSE;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
`endif
        ST_CLOSE: begin
          if (bit_cnt_q == 4'd8) begin
            state_d   = ST_IDLE;
            tx_d      = 1'b1;
            bit_cnt_d = 4'd0;
            txdone_d  = 1'b1;
          end else begin
            tx_d      = HDLC_FLAG[bit_cnt_q[2:0]];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_ABORT: begin
          tx_d = 1'b1;
          if (bit_cnt_q == 4'd8) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  // State, line and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      bit_cnt_q  <= 4'd0;
      flag_cnt_q <= 4'd0;
      sreg_q     <= 8'd0;
      last_q     <= 1'b0;
      ones_q     <= 3'd0;
      fin_q      <= 1'b0;
      txdone_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      bit_cnt_q  <= bit_cnt_d;
      flag_cnt_q <= flag_cnt_d;
      sreg_q     <= sreg_d;
      last_q     <= last_d;
      ones_q     <= ones_d;
      fin_q      <= fin_d;
      txdone_q   <= txdone_d;
      underrun_q <= underrun_d;
    end
  end

  assign tx_ready  = tx_ready_c & ~rst_i;
  assign tx        = tx_q;
  assign txdone    = txdone_q;
  assign underrun  = underrun_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_hdlc_tx_ctrl.sv
// Directed bench for hdlc_tx_ctrl. Instance a uses one opening flag,
// instance b uses two; inputs other than txen are shared.
module tb_hdlc_tx_ctrl;
  import hdlc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        txen_a, txen_b, bit_ce, tx_valid, tx_last;
  logic [7:0]  tx_data;
  logic        tx_ready_a, tx_a, txdone_a, underrun_a, busy_a;
  logic        tx_ready_b, tx_b, txdone_b, underrun_b, busy_b;
  hdlc_state_e state_a, state_b;

  hdlc_tx_ctrl #(.OPEN_FLAGS(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .txen(txen_a), .bit_ce(bit_ce),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready_a), .tx(tx_a), .txdone(txdone_a),
    .underrun(underrun_a), .busy(busy_a), .state_dbg(state_a)
  );

  hdlc_tx_ctrl #(.OPEN_FLAGS(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .txen(txen_b), .bit_ce(bit_ce),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready_b), .tx(tx_b), .txdone(txdone_b),
    .underrun(underrun_b), .busy(busy_b), .state_dbg(state_b)
  );

  // ---------------- bench state ----------------
  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int ce_period = 1;
  int start_cyc, txdone_cyc;
  int txdone_n, underrun_n, ready_n, ready_noce_n, hold_bad_n;
  bit sel_b = 1'b0;
  bit acc = 1'b0;
  logic prev_ce = 1'b0;
  logic last_tx = 1'b1;
  logic o_tx, o_ready, o_done, o_under, o_busy;
  hdlc_state_e o_state;

  bit         cap_q[$];     // serial bits, one per bit period
  logic [8:0] src_q[$];     // {last, data} transmit buffer
  logic [7:0] exp_q[$];     // expected decoded bytes
  logic [7:0] rx_q[$];      // bytes recovered by the receiver model

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_src();
    tx_valid = (src_q.size() > 0);
    tx_data  = tx_valid ? src_q[0][7:0] : 8'h00;
    tx_last  = tx_valid ? src_q[0][8] : 1'b0;
  endtask

  // One clock: update inputs after the falling edge, then sample outputs.
  task automatic tick();
    @(negedge clk);
    if (acc) void'(src_q.pop_front());
    acc = 1'b0;
    cyc++;
    bit_ce = (cyc % ce_period == 0);
    drive_src();
    #1;
    o_tx    = sel_b ? tx_b       : tx_a;
    o_ready = sel_b ? tx_ready_b : tx_ready_a;
    o_done  = sel_b ? txdone_b   : txdone_a;
    o_under = sel_b ? underrun_b : underrun_a;
    o_busy  = sel_b ? busy_b     : busy_a;
    o_state = sel_b ? state_b    : state_a;
    if (prev_ce) cap_q.push_back(o_tx);
    else if (o_tx !== last_tx) hold_bad_n++;
    if (o_done) begin txdone_n++; txdone_cyc = cyc; end
    if (o_under) underrun_n++;
    if (o_ready) begin
      ready_n++;
      if (!bit_ce) ready_noce_n++;
    end
    acc     = o_ready && tx_valid;
    last_tx = o_tx;
    prev_ce = bit_ce;
  endtask

  task automatic clear_stats();
    txdone_n = 0; underrun_n = 0; ready_n = 0; ready_noce_n = 0; hold_bad_n = 0;
    txdone_cyc = -1;
    cap_q.delete();
  endtask

  // Start a frame from src_q, drop txen once busy, wait (bounded) for IDLE.
  task automatic run_frame(input bit use_b, input int period, input int budget);
    bit seen = 1'b0;
    bit fin = 1'b0;
    sel_b = use_b;
    ce_period = period;
    clear_stats();
    if (use_b) txen_b = 1'b1; else txen_a = 1'b1;
    drive_src();
    start_cyc = cyc;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (o_busy) begin
        seen = 1'b1;
        txen_a = 1'b0;
        txen_b = 1'b0;
      end else if (seen) begin
        fin = 1'b1;
        break;
      end
    end
    txen_a = 1'b0;
    txen_b = 1'b0;
    check("frame_end", fin, 1'b1);
    repeat (6) tick();
  endtask

  // ---------------- receiver model / scoreboard ----------------
  function automatic logic [127:0] cap_vec(input int n);
    logic [127:0] v = '0;
    int i = 0;
    while (i < cap_q.size() && cap_q[i]) i++;
    if (cap_q.size() - i < n) return 'x;
    for (int k = 0; k < n; k++) v = {v[126:0], cap_q[i + k]};
    return v;
  endfunction

  function automatic logic [127:0] str_vec(input string s);
    logic [127:0] v = '0;
    for (int k = 0; k < s.len(); k++) v = {v[126:0], (s[k] == 8'h31)};
    return v;
  endfunction

  function automatic logic [15:0] crc_bytes(input logic [7:0] b[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (b[j]) begin
      c = c ^ {8'h00, b[j]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  // Skip idle and opening flags, destuff, collect bytes up to the closing flag.
  task automatic decode_frame(input int nflags);
    int i = 0;
    int ones = 0;
    int nb = 0;
    logic [7:0] sh = 8'h00;
    bit b;
    rx_q.delete();
    while (i < cap_q.size() && cap_q[i]) i++;
    i += 8 * nflags;
    while (i < cap_q.size()) begin
      b = cap_q[i];
      i++;
      if (ones == 5) begin
        if (b) break;
        ones = 0;
      end else begin
        ones = b ? ones + 1 : 0;
        sh = {b, sh[7:1]};
        nb++;
        if (nb == 8) begin
          rx_q.push_back(sh);
          nb = 0;
        end
      end
    end
  endtask

  task automatic score_rx();
    check("rx_count", rx_q.size(), exp_q.size());
    for (int k = 0; k < rx_q.size() && exp_q.size() > 0; k++) begin
      check("rx_byte", rx_q[k], exp_q.pop_front());
    end
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; txen_a = 1'b0; txen_b = 1'b0; bit_ce = 1'b0;
    tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
    repeat (3) tick();
    check("rst_tx_a", tx_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_ready_a", tx_ready_a, 1'b0);
    check("rst_done_a", txdone_a, 1'b0);
    check("rst_under_a", underrun_a, 1'b0);
    check("rst_state_a", state_a, ST_IDLE);
    check("rst_tx_b", tx_b, 1'b1);
    rst = 1'b0;
    repeat (3) tick();

`ifndef HDLC_TX_FCS_EN
    // Single 0x00 byte.
    src_q.push_back({1'b1, 8'h00});
    run_frame(1'b0, 1, 100);
    check("b00_bits", cap_vec(25), str_vec("0111111000000000011111101"));
    check("b00_done_n", txdone_n, 1);
    check("b00_done_lat", txdone_cyc - start_cyc, 25);
    check("b00_under_n", underrun_n, 0);
    check("b00_ready_n", ready_n, 1);

    // 0xFF: zero inserted after the fifth 1.
    src_q.push_back({1'b1, 8'hFF});
    run_frame(1'b0, 1, 100);
    check("bff_bits", cap_vec(26), str_vec("01111110111110111011111101"));
    check("bff_done_n", txdone_n, 1);
`endif

    // Underrun: 0x01 then nothing.
    src_q.push_back({1'b0, 8'h01});
    run_frame(1'b0, 1, 100);
    check("abort_bits", cap_vec(25), str_vec("0111111010000000111111111"));
    check("abort_under_n", underrun_n, 1);
    check("abort_done_n", txdone_n, 0);
    check("abort_busy", o_busy, 1'b0);
    check("abort_state", o_state, ST_IDLE);

`ifdef HDLC_TX_FCS_EN
    // "123456789" with FCS.
    for (int k = 0; k < 9; k++) begin
      src_q.push_back({(k == 8), 8'(8'h31 + k)});
      exp_q.push_back(8'(8'h31 + k));
    end
    exp_q.push_back(8'h6E);
    exp_q.push_back(8'h90);
    run_frame(1'b0, 1, 400);
    decode_frame(1);
    check("fcs_residue", crc_bytes(rx_q), 16'hF0B8);
    score_rx();
    check("fcs_done_n", txdone_n, 1);
`endif

    // Reset in the middle of the data field.
    sel_b = 1'b0;
    ce_period = 1;
    src_q.push_back({1'b0, 8'hAA});
    src_q.push_back({1'b0, 8'hBB});
    src_q.push_back({1'b1, 8'hCC});
    txen_a = 1'b1;
    drive_src();
    tick();
    txen_a = 1'b0;
    repeat (13) tick();
    check("mid_busy_pre", o_busy, 1'b1);
    clear_stats();
    rst = 1'b1;
    tick();
    check("mid_rst_tx", o_tx, 1'b1);
    check("mid_rst_busy", o_busy, 1'b0);
    rst = 1'b0;
    src_q.delete();
    acc = 1'b0;
    drive_src();
    repeat (30) tick();
    check("mid_rst_done_n", txdone_n, 0);
    check("mid_rst_under_n", underrun_n, 0);
    src_q.push_back({1'b1, 8'h5A});
    exp_q.push_back(8'h5A);
`ifdef HDLC_TX_FCS_EN
    begin
      logic [7:0] one_b[$];
      logic [15:0] fcs;
      one_b.push_back(8'h5A);
      fcs = ~crc_bytes(one_b);
      exp_q.push_back(fcs[7:0]);
      exp_q.push_back(fcs[15:8]);
    end
`endif
    run_frame(1'b0, 1, 200);
    decode_frame(1);
    score_rx();
    check("post_rst_done_n", txdone_n, 1);

    // bit_ce every third cycle, two opening flags.
    src_q.push_back({1'b1, 8'h81});
    run_frame(1'b1, 3, 400);
`ifndef HDLC_TX_FCS_EN
    check("slow_bits", cap_vec(32), str_vec("01111110011111101000000101111110"));
`endif
    check("slow_hold", hold_bad_n, 0);
    check("slow_ready_ce", ready_noce_n, 0);
    check("slow_ready_n", ready_n, 1);
    check("slow_done_n", txdone_n, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/hdlc_tx_ctrl.md
HDLC_TX_CTRL -- requirements
Module: hdlc_tx_ctrl

Interface
REQ-001 Parameter OPEN_FLAGS, default 1, sets the number of opening flags (0x7E) sent per frame; legal range 1..15.
REQ-002 clk_i  input  1  sole clock; all logic on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 txen  input  1  frame enable; a new frame starts only while high.
REQ-005 bit_ce  input  1  bit-rate strobe; one serial bit advances per clk_i cycle with bit_ce high.
REQ-006 tx_data  input  8  byte from the transmit buffer.
REQ-007 tx_valid  input  1  tx_data valid.
REQ-008 tx_last  input  1  qualifies tx_data as the final byte of the frame.
REQ-009 tx_ready  output  1  byte accepted in this cycle when tx_valid is also high.
REQ-010 tx  output  1  serial HDLC line, LSB first.
REQ-011 txdone  output  1  one-cycle pulse after the closing flag completes.
REQ-012 underrun  output  1  one-cycle pulse when a frame is aborted.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States: IDLE, OPEN, DATA, FCS, CLOSE, ABORT.
REQ-015 IDLE: tx=1, tx_ready=0. Go to OPEN on a bit_ce cycle with txen=1 and tx_valid=1.
REQ-016 OPEN: send OPEN_FLAGS x 0x7E unstuffed (bit order 0,1,1,1,1,1,1,0).
- tx_ready pulses on the bit_ce cycle that sends the last flag bit, loading the first byte.
- Go to DATA.
REQ-017 DATA: shift the loaded byte out LSB first.
- On the bit_ce cycle carrying bit 7 of a non-last byte, assert tx_ready; if tx_valid, load the next byte.
- If tx_valid is low, go to ABORT.
- After the last byte, go to FCS (CLOSE if the FCS feature is absent).
REQ-018 Zero insertion: in DATA and FCS, after five consecutive 1 bits on tx, the next bit_ce sends an inserted 0.
- The inserted bit does not consume a data bit.
- The ones-run counter clears on every 0 sent and on entry to DATA.
REQ-019 tx_ready is asserted only in a cycle where bit_ce is high; the byte is taken in that same cycle.
REQ-020 CLOSE: send one unstuffed 0x7E, pulse txdone on the cycle after its last bit, then go to IDLE.
- Back-to-back frames re-enter OPEN from IDLE on the next qualifying bit_ce.
REQ-021 ABORT: send eight 1 bits unstuffed, pulse underrun on entry, then go to IDLE; txdone is not pulsed.
REQ-022 Dropping txen mid-frame has no effect; it gates only frame start.
REQ-023 bit_ce held low freezes all state, tx and counters.
REQ-024 tx is registered.

Reset
REQ-025 With rst_i high at a clock edge: state=IDLE, tx=1, tx_ready=0, txdone=0, underrun=0, busy=0, all counters and shift registers 0, FCS register 0xFFFF.
REQ-026 Reset mid-frame abandons the frame immediately; no abort sequence and no pulses are produced.

Configuration
REQ-027 Macro HDLC_TX_FCS_EN defined: CRC-16-CCITT is computed and sent in the FCS state.
- Polynomial x^16+x^12+x^5+1, reflected, preset 0xFFFF.
- Computed over data bits only, inserted zeros excluded.
- The ones' complement is sent LSB first, with zero insertion.
REQ-028 Macro HDLC_TX_FCS_EN undefined: the FCS state and CRC logic are absent; DATA goes directly to CLOSE.

Structure
REQ-029 Shared package hdlc_pkg holds:
- the state enum;
- HDLC_FLAG=8'h7E;
- CRC_POLY_REFL=16'h8408;
- CRC_INIT=16'hFFFF;
- CRC_GOOD=16'hF0B8.
REQ-030 The CRC is a sub-module hdlc_crc16 (clk_i, rst_i, init, ce, din, crc).
- It is reused by the future receiver.

Verification
REQ-031 Single byte 0x00 with tx_last, OPEN_FLAGS=1, bit_ce every cycle, FCS off.
- tx = 01111110 00000000 01111110.
- txdone pulses once, 25 cycles after start.
REQ-032 Byte 0xFF, FCS off.
- Data field = 11111011 1 (one zero inserted after the fifth 1).
- The closing flag follows unstuffed.
REQ-033 Frame 0x01,0x02 with tx_valid dropped before the second byte.
- The 0x01 bits are followed by eight 1s.
- underrun pulses; no txdone; IDLE, busy=0.
REQ-034 FCS on, frame "123456789" (ASCII).
- Transmitted FCS bytes are 0x6E then 0x90.
- A receiver model's CRC over data plus FCS equals 0xF0B8.
REQ-035 rst_i asserted mid-DATA.
- Next cycle: tx=1, busy=0; no txdone or underrun.
- A following frame is sent correctly.
REQ-036 bit_ce asserted every 3rd cycle, OPEN_FLAGS=2.
- Two opening flags; each tx bit is held 3 cycles.
- tx_ready pulses coincide with bit_ce only.
